err_signal_gen_v2: RTL and testbench

Parametrised successor error-signal generator for the IRIS loop. Per modulation period it samples ADC data in the low phase, then in the high phase. Each phase has a trigger, a settle-wait and a 2^N-sample average. It outputs a signed, offset-corrected, saturated error with a one-cycle valid strobe. Additions over the previous generation:
- ADC sample-valid qualification
- Parametrised accumulator and output widths
- Averaging-select clamping
- Saturation and trigger-miss flags
- Enable-driven abort

---
 rtl/err_signal_gen_v2_if.sv | 35 +++
 rtl/err_signal_gen_v2.sv | 175 +++++++++++++++++
 tb/tb_err_signal_gen_v2.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/err_signal_gen_v2_if.sv
// Control/data bundle for the IRIS error-signal generator.
// The master side drives the i_* controls and ADC data. The slave side (the generator) drives the o_* results.
interface err_signal_gen_v2_if #(
    parameter int ADC_BIT  = 14,
    parameter int OUT_BIT  = 32,
    parameter int WAIT_BIT = 32,
    parameter int SEL_BIT  = 4
);
    logic                       i_en;
    logic                       i_polarity;
    logic                       i_trig;
    logic                       i_adc_vld;
    logic signed [ADC_BIT-1:0]  i_adc_data;
    logic        [WAIT_BIT-1:0] i_wait_cnt;
    logic signed [OUT_BIT-1:0]  i_err_offset;
    logic        [SEL_BIT-1:0]  i_avg_sel;
    logic signed [OUT_BIT-1:0]  o_err;
    logic                       o_err_vld;
    logic                       o_sat;
    logic                       o_trig_miss;
    logic                       o_sel_clamp;
    logic                       o_phase;

    modport master (
        output i_en, i_polarity, i_trig, i_adc_vld, i_adc_data,
               i_wait_cnt, i_err_offset, i_avg_sel,
        input  o_err, o_err_vld, o_sat, o_trig_miss, o_sel_clamp, o_phase
    );

    modport slave (
        input  i_en, i_polarity, i_trig, i_adc_vld, i_adc_data,
               i_wait_cnt, i_err_offset, i_avg_sel,
        output o_err, o_err_vld, o_sat, o_trig_miss, o_sel_clamp, o_phase
    );
endinterface

// File: rtl/err_signal_gen_v2.sv
// Two-phase error-signal generator for the IRIS loop.
// Each period averages the low-phase and high-phase ADC samples, then emits a saturated, offset-corrected difference.
module err_signal_gen_v2 #(
    parameter int ADC_BIT  = 14,
    parameter int OUT_BIT  = 32,
    parameter int AVG_MAX  = 10,
    parameter int WAIT_BIT = 32,
    parameter int SEL_BIT  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    err_signal_gen_v2_if.slave bus
);
    localparam int ACC_W = ADC_BIT + AVG_MAX;
    localparam int CNT_W = AVG_MAX + 1;
    localparam int SW    = (AVG_MAX < 1) ? 1 : $clog2(AVG_MAX + 1);
    localparam int CW    = OUT_BIT + 2;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] WAIT_L = 4'd1;
    localparam logic [3:0] STAB_L = 4'd2;
    localparam logic [3:0] ACQ_L  = 4'd3;
    localparam logic [3:0] WAIT_H = 4'd4;
    localparam logic [3:0] STAB_H = 4'd5;
    localparam logic [3:0] ACQ_H  = 4'd6;
    localparam logic [3:0] CALC   = 4'd7;
    localparam logic [3:0] OUT    = 4'd8;

    logic        [3:0]         state_q, state_d;
    logic        [WAIT_BIT-1:0] wait_q, wait_d;
    logic        [SW-1:0]      sel_q, sel_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [ADC_BIT-1:0] low_avg_q, low_avg_d;
    logic signed [ADC_BIT-1:0] high_avg_q, high_avg_d;
    logic signed [OUT_BIT-1:0] err_q, err_d;
    logic                      sat_q, sat_d;
    logic                      err_vld_q, err_vld_d;
    logic                      trig_miss_q, trig_miss_d;
    logic                      sel_clamp_q, sel_clamp_d;

    logic signed [ACC_W-1:0]   adc_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ADC_BIT-1:0] avg_val;
    logic                      sample_last;
    logic                      sel_over;
    logic signed [CW-1:0]      low_ext, high_ext, off_ext, diff, calc_sum;
    logic                      calc_in_range;
    logic signed [OUT_BIT-1:0] calc_err;

    assign adc_ext     = {{AVG_MAX{bus.i_adc_data[ADC_BIT-1]}}, bus.i_adc_data};
    assign acc_sum     = acc_q + adc_ext;
    // Arithmetic shift floors the average toward -inf.
    assign avg_val     = ADC_BIT'(acc_sum >>> sel_q);
    assign sample_last = (cnt_q + CNT_W'(1)) == (CNT_W'(1) << sel_q);
    assign sel_over    = 32'(bus.i_avg_sel) > 32'(AVG_MAX);

    assign low_ext  = {{(CW-ADC_BIT){low_avg_q[ADC_BIT-1]}}, low_avg_q};
    assign high_ext = {{(CW-ADC_BIT){high_avg_q[ADC_BIT-1]}}, high_avg_q};
    assign off_ext  = {{2{bus.i_err_offset[OUT_BIT-1]}}, bus.i_err_offset};
    assign diff     = bus.i_polarity ? (low_ext - high_ext) : (high_ext - low_ext);
    assign calc_sum = diff + off_ext;
    // The sum fits in OUT_BIT bits only if its top three bits agree.
    assign calc_in_range = (&calc_sum[CW-1:OUT_BIT-1]) | ~(|calc_sum[CW-1:OUT_BIT-1]);
    assign calc_err = calc_in_range ? calc_sum[OUT_BIT-1:0]
                    : (calc_sum[CW-1] ? {1'b1, {(OUT_BIT-1){1'b0}}}
                                      : {1'b0, {(OUT_BIT-1){1'b1}}});

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        sel_d       = sel_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        low_avg_d   = low_avg_q;
        high_avg_d  = high_avg_q;
        err_d       = err_q;
        sat_d       = sat_q;
        err_vld_d   = 1'b0;
        trig_miss_d = 1'b0;
        sel_clamp_d = sel_clamp_q;
        if (!bus.i_en) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_L;
                WAIT_L: begin
                    if (bus.i_trig) begin
                        wait_d  = bus.i_wait_cnt;
                        sel_d   = sel_over ? SW'(AVG_MAX) : SW'(bus.i_avg_sel);
                        if (sel_over) sel_clamp_d = 1'b1;
                        state_d = STAB_L;
                    end
                end
                WAIT_H: begin
                    if (bus.i_trig) begin
                        wait_d  = bus.i_wait_cnt;
                        state_d = STAB_H;
                    end
                end
                STAB_L, STAB_H: begin
                    trig_miss_d = bus.i_trig;
                    if (wait_q == '0) state_d = (state_q == STAB_L) ? ACQ_L : ACQ_H;
                    else              wait_d  = wait_q - WAIT_BIT'(1);
                end
                ACQ_L, ACQ_H: begin
                    trig_miss_d = bus.i_trig;
                    if (bus.i_adc_vld) begin
                        if (sample_last) begin
                            acc_d = '0;
                            cnt_d = '0;
                            if (state_q == ACQ_L) begin
                                low_avg_d = avg_val;
                                state_d   = WAIT_H;
                            end else begin
                                high_avg_d = avg_val;
                                state_d    = CALC;
                            end
                        end else begin
                            acc_d = acc_sum;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                CALC: begin
                    err_d     = calc_err;
                    sat_d     = ~calc_in_range;
                    err_vld_d = 1'b1;
                    state_d   = OUT;
                end
                OUT:     state_d = WAIT_L;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            sel_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            low_avg_q   <= '0;
            high_avg_q  <= '0;
            err_q       <= '0;
            sat_q       <= 1'b0;
            err_vld_q   <= 1'b0;
            trig_miss_q <= 1'b0;
            sel_clamp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            sel_q       <= sel_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            low_avg_q   <= low_avg_d;
            high_avg_q  <= high_avg_d;
            err_q       <= err_d;
            sat_q       <= sat_d;
            err_vld_q   <= err_vld_d;
            trig_miss_q <= trig_miss_d;
            sel_clamp_q <= sel_clamp_d;
        end
    end

    assign bus.o_err       = err_q;
    assign bus.o_err_vld   = err_vld_q;
    assign bus.o_sat       = sat_q;
    assign bus.o_trig_miss = trig_miss_q;
    assign bus.o_sel_clamp = sel_clamp_q;
    assign bus.o_phase     = (state_q == WAIT_H) || (state_q == STAB_H) || (state_q == ACQ_H);
endmodule

// File: tb/tb_err_signal_gen_v2.sv
// Directed bench for err_signal_gen_v2: one task per scenario, hand-computed expectations.
module tb_err_signal_gen_v2;
    localparam int ADC_BIT  = 14;
    localparam int OUT_BIT  = 16;
    localparam int AVG_MAX  = 10;
    localparam int WAIT_BIT = 32;
    localparam int SEL_BIT  = 4;
    localparam int JUNK     = 8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   vld_pulses = 0;
    int   miss_pulses = 0;
    logic phase_l, phase_h;
    int   low_q[$];
    int   high_q[$];

    err_signal_gen_v2_if #(.ADC_BIT(ADC_BIT), .OUT_BIT(OUT_BIT), .WAIT_BIT(WAIT_BIT),
                           .SEL_BIT(SEL_BIT)) bus ();

    err_signal_gen_v2 #(.ADC_BIT(ADC_BIT), .OUT_BIT(OUT_BIT), .AVG_MAX(AVG_MAX),
                        .WAIT_BIT(WAIT_BIT), .SEL_BIT(SEL_BIT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.o_err_vld)   vld_pulses++;
        if (bus.o_trig_miss) miss_pulses++;
    endtask

    task automatic stab(input int wt);
        bus.i_adc_vld  = 1'b1;
        bus.i_adc_data = ADC_BIT'(JUNK);
        for (int i = 0; i <= wt; i++) tick();
        bus.i_adc_vld  = 1'b0;
    endtask

    task automatic feed(input int v, input bit alt, input bit trig);
        if (alt) begin
            bus.i_adc_vld  = 1'b0;
            bus.i_adc_data = ADC_BIT'(JUNK);
            tick();
        end
        bus.i_adc_vld  = 1'b1;
        bus.i_adc_data = ADC_BIT'(v);
        bus.i_trig     = trig;
        tick();
        bus.i_trig     = 1'b0;
        bus.i_adc_vld  = 1'b0;
    endtask

    // Starts in WAIT_L; ends in CALC when n_high equals the high queue size.
    task automatic run_period(input int sel, input int wt, input bit alt,
                              input int miss_idx, input int n_high);
        bus.i_avg_sel  = SEL_BIT'(sel);
        bus.i_wait_cnt = WAIT_BIT'(wt);
        bus.i_trig = 1'b1; tick(); bus.i_trig = 1'b0;
        phase_l = bus.o_phase;
        stab(wt);
        for (int i = 0; i < low_q.size(); i++) feed(low_q[i], alt, i == miss_idx);
        bus.i_trig = 1'b1; tick(); bus.i_trig = 1'b0;
        phase_h = bus.o_phase;
        stab(wt);
        for (int i = 0; i < n_high; i++) feed(high_q[i], alt, 1'b0);
    endtask

    task automatic fill(input int lv, input int hv, input int n);
        low_q.delete();
        high_q.delete();
        for (int i = 0; i < n; i++) begin
            low_q.push_back(lv);
            high_q.push_back(hv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_en = 1'b0; bus.i_polarity = 1'b0; bus.i_trig = 1'b0;
        bus.i_adc_vld = 1'b0; bus.i_adc_data = '0; bus.i_wait_cnt = '0;
        bus.i_err_offset = '0; bus.i_avg_sel = '0;
        repeat (3) tick();
        checks++; if (bus.o_err !== '0) begin errors++; $display("FAIL reset_err: got %0d expected 0", bus.o_err); end
        checks++; if (bus.o_err_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", bus.o_err_vld); end
        checks++; if (bus.o_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", bus.o_sat); end
        checks++; if (bus.o_trig_miss !== 1'b0) begin errors++; $display("FAIL reset_miss: got %b expected 0", bus.o_trig_miss); end
        checks++; if (bus.o_sel_clamp !== 1'b0) begin errors++; $display("FAIL reset_clamp: got %b expected 0", bus.o_sel_clamp); end
        checks++; if (bus.o_phase !== 1'b0) begin errors++; $display("FAIL reset_phase: got %b expected 0", bus.o_phase); end
        rst = 1'b0;
        bus.i_en = 1'b1;
        tick();
        vld_pulses = 0;
        $display("reset released, enable high");
    endtask

    task automatic test_basic();
        fill(100, 300, 4);
        run_period(2, 3, 1'b0, -1, 4);
        checks++; if (bus.o_err_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_early: got %b expected 0", bus.o_err_vld); end
        tick();
        $display("basic period: err=%0d sat=%b vld=%b", bus.o_err, bus.o_sat, bus.o_err_vld);
        checks++; if (bus.o_err_vld !== 1'b1) begin errors++; $display("FAIL basic_vld: got %b expected 1", bus.o_err_vld); end
        checks++; if (bus.o_err !== OUT_BIT'(200)) begin errors++; $display("FAIL basic_err: got %0d expected 200", bus.o_err); end
        checks++; if (bus.o_sat !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b expected 0", bus.o_sat); end
        tick();
        checks++; if (bus.o_err_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_end: got %b expected 0", bus.o_err_vld); end
        checks++; if (vld_pulses != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", vld_pulses); end
        checks++; if (phase_l !== 1'b0 || phase_h !== 1'b1) begin errors++; $display("FAIL basic_phase: got %b%b expected 01", phase_l, phase_h); end
    endtask

    task automatic test_polarity_floor();
        fill(100, 300, 4);
        bus.i_polarity = 1'b1;
        bus.i_err_offset = OUT_BIT'(5);
        run_period(2, 3, 1'b0, -1, 4);
        tick();
        $display("polarity period: err=%0d vld=%b", $signed(bus.o_err), bus.o_err_vld);
        checks++; if (bus.o_err !== OUT_BIT'(-195)) begin errors++; $display("FAIL pol_err: got %0d expected -195", $signed(bus.o_err)); end
        tick();
        low_q = '{-3, -2, -2, -2};
        high_q = '{0, 0, 0, 0};
        bus.i_polarity = 1'b0;
        bus.i_err_offset = '0;
        run_period(2, 1, 1'b0, -1, 4);
        tick();
        $display("floor period: err=%0d vld=%b", $signed(bus.o_err), bus.o_err_vld);
        checks++; if (bus.o_err !== OUT_BIT'(3)) begin errors++; $display("FAIL floor_err: got %0d expected 3", $signed(bus.o_err)); end
        tick();
    endtask

    task automatic test_saturation();
        low_q = '{-8192}; high_q = '{8191};
        bus.i_err_offset = OUT_BIT'(32767);
        run_period(0, 0, 1'b0, -1, 1);
        tick();
        $display("sat+ period: err=%0d sat=%b", $signed(bus.o_err), bus.o_sat);
        checks++; if (bus.o_err !== OUT_BIT'(32767)) begin errors++; $display("FAIL satp_err: got %0d expected 32767", $signed(bus.o_err)); end
        checks++; if (bus.o_sat !== 1'b1) begin errors++; $display("FAIL satp_flag: got %b expected 1", bus.o_sat); end
        tick();
        bus.i_polarity = 1'b1;
        bus.i_err_offset = OUT_BIT'(-32768);
        run_period(0, 0, 1'b0, -1, 1);
        tick();
        $display("sat- period: err=%0d sat=%b", $signed(bus.o_err), bus.o_sat);
        checks++; if (bus.o_err !== OUT_BIT'(-32768)) begin errors++; $display("FAIL satn_err: got %0d expected -32768", $signed(bus.o_err)); end
        checks++; if (bus.o_sat !== 1'b1) begin errors++; $display("FAIL satn_flag: got %b expected 1", bus.o_sat); end
        tick();
        low_q = '{10}; high_q = '{20};
        bus.i_polarity = 1'b0;
        bus.i_err_offset = '0;
        run_period(0, 0, 1'b0, -1, 1);
        tick();
        $display("unsat period: err=%0d sat=%b", $signed(bus.o_err), bus.o_sat);
        checks++; if (bus.o_err !== OUT_BIT'(10)) begin errors++; $display("FAIL unsat_err: got %0d expected 10", $signed(bus.o_err)); end
        checks++; if (bus.o_sat !== 1'b0) begin errors++; $display("FAIL unsat_flag: got %b expected 0", bus.o_sat); end
        tick();
    endtask

    task automatic test_vld_gap_trig_miss();
        low_q = '{1, 2, 3, 4, 5, 6, 7, 8};
        high_q = '{10, 20, 30, 40, 50, 60, 70, 80};
        miss_pulses = 0;
        vld_pulses = 0;
        run_period(3, 2, 1'b1, 3, 8);
        tick();
        $display("gap period: err=%0d misses=%0d", $signed(bus.o_err), miss_pulses);
        checks++; if (bus.o_err !== OUT_BIT'(41)) begin errors++; $display("FAIL gap_err: got %0d expected 41", $signed(bus.o_err)); end
        checks++; if (miss_pulses != 1) begin errors++; $display("FAIL gap_miss: got %0d expected 1", miss_pulses); end
        checks++; if (vld_pulses != 1) begin errors++; $display("FAIL gap_pulses: got %0d expected 1", vld_pulses); end
        tick();
    endtask

    task automatic test_sel_clamp();
        checks++; if (bus.o_sel_clamp !== 1'b0) begin errors++; $display("FAIL clamp_pre: got %b expected 0", bus.o_sel_clamp); end
        fill(-100, 50, 1024);
        run_period(15, 0, 1'b0, -1, 1024);
        tick();
        $display("clamp period: err=%0d clamp=%b vld=%b", $signed(bus.o_err), bus.o_sel_clamp, bus.o_err_vld);
        checks++; if (bus.o_err_vld !== 1'b1) begin errors++; $display("FAIL clamp_vld: got %b expected 1", bus.o_err_vld); end
        checks++; if (bus.o_err !== OUT_BIT'(150)) begin errors++; $display("FAIL clamp_err: got %0d expected 150", $signed(bus.o_err)); end
        tick();
        low_q = '{0, 0}; high_q = '{4, 4};
        run_period(1, 0, 1'b0, -1, 2);
        tick();
        $display("post-clamp period: err=%0d clamp=%b", $signed(bus.o_err), bus.o_sel_clamp);
        checks++; if (bus.o_err !== OUT_BIT'(4)) begin errors++; $display("FAIL clamp_next_err: got %0d expected 4", $signed(bus.o_err)); end
        checks++; if (bus.o_sel_clamp !== 1'b1) begin errors++; $display("FAIL clamp_sticky: got %b expected 1", bus.o_sel_clamp); end
        tick();
    endtask

    task automatic test_abort_reset();
        fill(50, 60, 4);
        run_period(2, 1, 1'b0, -1, 2);
        checks++; if (bus.o_phase !== 1'b1) begin errors++; $display("FAIL abort_phase_pre: got %b expected 1", bus.o_phase); end
        vld_pulses = 0;
        bus.i_en = 1'b0;
        repeat (3) tick();
        $display("abort: err=%0d phase=%b pulses=%0d", $signed(bus.o_err), bus.o_phase, vld_pulses);
        checks++; if (bus.o_phase !== 1'b0) begin errors++; $display("FAIL abort_phase: got %b expected 0", bus.o_phase); end
        checks++; if (bus.o_err !== OUT_BIT'(4)) begin errors++; $display("FAIL abort_hold: got %0d expected 4", $signed(bus.o_err)); end
        checks++; if (vld_pulses != 0) begin errors++; $display("FAIL abort_pulses: got %0d expected 0", vld_pulses); end
        bus.i_en = 1'b1;
        tick();
        run_period(2, 1, 1'b0, -1, 4);
        tick();
        $display("after abort period: err=%0d", $signed(bus.o_err));
        checks++; if (bus.o_err !== OUT_BIT'(10)) begin errors++; $display("FAIL abort_next_err: got %0d expected 10", $signed(bus.o_err)); end
        tick();
        bus.i_avg_sel = SEL_BIT'(12);
        bus.i_wait_cnt = WAIT_BIT'(5);
        bus.i_trig = 1'b1; tick(); bus.i_trig = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        $display("reset mid STAB_L: err=%0d sat=%b clamp=%b", $signed(bus.o_err), bus.o_sat, bus.o_sel_clamp);
        checks++; if (bus.o_err !== '0) begin errors++; $display("FAIL rst_err: got %0d expected 0", $signed(bus.o_err)); end
        checks++; if (bus.o_sel_clamp !== 1'b0) begin errors++; $display("FAIL rst_clamp: got %b expected 0", bus.o_sel_clamp); end
        checks++; if (bus.o_phase !== 1'b0 || bus.o_err_vld !== 1'b0) begin errors++; $display("FAIL rst_phase_vld: got %b%b expected 00", bus.o_phase, bus.o_err_vld); end
        rst = 1'b0;
        tick();
        fill(7, 9, 2);
        run_period(1, 0, 1'b0, -1, 2);
        tick();
        $display("after reset period: err=%0d", $signed(bus.o_err));
        checks++; if (bus.o_err !== OUT_BIT'(2) || bus.o_err_vld !== 1'b1) begin errors++; $display("FAIL rst_next_err: got %0d/%b expected 2/1", $signed(bus.o_err), bus.o_err_vld); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_polarity_floor();
        test_saturation();
        test_vld_gap_trig_miss();
        test_sel_clamp();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
